// File: rtl/aq_djpeg_bytebuf_if.sv
// aq_djpeg_bytebuf_if: word-in / byte-window-out bundle
// between the stream FIFO, the byte buffer and the marker FSM.
interface aq_djpeg_bytebuf_if;
    logic        Flush;
    logic [31:0] InData;
    logic [2:0]  InBytes;
    logic        InValid;
    logic        InLast;
    logic        InReady;
    logic [31:0] DataOut;
    logic        DataOutEnable;
    logic        DataOutEnd;
    logic        UseByte;
    logic        UseWord;

    modport master (
        output Flush, InData, InBytes, InValid, InLast,
        output UseByte, UseWord,
        input  InReady, DataOut, DataOutEnable, DataOutEnd
    );

    modport slave (
        input  Flush, InData, InBytes, InValid, InLast,
        input  UseByte, UseWord,
        output InReady, DataOut, DataOutEnable, DataOutEnd
    );
endinterface

// File: rtl/aq_djpeg_bytebuf.sv
// aq_djpeg_bytebuf: 8-byte alignment buffer feeding the JPEG
// marker FSM a byte-aligned 32-bit window.
module aq_djpeg_bytebuf #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input logic         clk,
    input logic         rst,
    aq_djpeg_bytebuf_if.slave bus
);

    logic [63:0] data_buf;
    logic [3:0]  count;
    logic        end_seen;

    logic        accept;
    logic [2:0]  take;
    logic [3:0]  consume;
    logic [3:0]  base;
    logic [31:0] lane_mask;
    logic [63:0] ins_data;
    logic [63:0] ins_mask;
    logic [63:0] next_buf;
    logic [3:0]  next_count;
    logic [31:0] win;

    assign bus.InReady       = (count <= 4'd4) && !end_seen;
    assign accept            = bus.InValid && bus.InReady;
    assign bus.DataOutEnable = (count >= 4'd4) || (end_seen && count != 4'd0);
    assign bus.DataOutEnd    = end_seen && (count == 4'd0);
    assign bus.DataOut       = win;

    // Window: oldest four bytes, lanes past the valid count read as pad
    always_comb begin
        win = '0;
        for (int i = 0; i < 4; i++) begin
            win[31-8*i -: 8] = (4'(i) < count) ? data_buf[63-8*i -: 8]
                                               : PAD_BYTE;
        end
    end

    // Next state: shift out consumed bytes, then append the new word behind
    // whatever remains so accept and consume can overlap in one cycle
    always_comb begin
        take = (bus.InBytes inside {3'd1, 3'd2, 3'd3}) ? bus.InBytes : 3'd4;
        consume = 4'd0;
        if (bus.DataOutEnable) begin
            if (bus.UseWord) begin
                consume = 4'd2;
            end else if (bus.UseByte) begin
                consume = 4'd1;
            end
        end
        if (consume > count) begin
            consume = count;
        end
        base = count - consume;
        unique case (take)
            3'd1:    lane_mask = 32'hFF00_0000;
            3'd2:    lane_mask = 32'hFFFF_0000;
            3'd3:    lane_mask = 32'hFFFF_FF00;
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
        ins_data   = {bus.InData & lane_mask, 32'h0} >> {base, 3'b000};
        ins_mask   = {lane_mask, 32'h0} >> {base, 3'b000};
        next_buf   = data_buf << {consume, 3'b000};
        next_count = base;
        if (accept) begin
            next_buf   = (next_buf & ~ins_mask) | ins_data;
            next_count = base + {1'b0, take};
        end
    end

    // State register; reset and flush both clear the stream
    always_ff @(posedge clk) begin
        if (!rst || bus.Flush) begin
            data_buf <= '0;
            count    <= '0;
            end_seen <= 1'b0;
        end else begin
            data_buf <= next_buf;
            count    <= next_count;
            if (accept && bus.InLast) begin
                end_seen <= 1'b1;
            end
        end
    end

    // Short words are only legal as the final word of a stream
    a_short_only_last : assert property (
        @(posedge clk) disable iff (!rst || bus.Flush)
        (accept && !bus.InLast) |-> !(bus.InBytes inside {3'd1, 3'd2, 3'd3})
    );

endmodule
